// File: rtl/array_cla_multiplier.sv
// 16x16 unsigned array multiplier: partial-product rows accumulated through
// chained 16-bit carry-lookahead adders, followed by a single output register.
module array_cla_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    output logic [31:0] product
);

    logic [31:0]       product_q, product_d;
    logic              valid_q;
    logic [15:0][15:0] pp;
    logic [15:0]       sum_row;
    logic              carry_row;

    // 16-bit CLA: four 4-bit lookahead blocks with group G/P, and lookahead
    // carries between blocks. Returns {carry_out, sum}.
    function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] g, p, c;
        logic [3:0]  gg, gp;
        logic [4:0]  bc;
        g = x & y;
        p = x ^ y;
        for (int unsigned k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        bc[0] = 1'b0;
        bc[1] = gg[0];
        bc[2] = gg[1] | (gp[1] & gg[0]);
        bc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]);
        bc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
        for (int unsigned k = 0; k < 4; k++) begin
            c[4*k]   = bc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
        end
        return {bc[4], p ^ c};
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            for (int unsigned j = 0; j < 16; j++) begin
                pp[i][j] = a[j] & b[i];
            end
        end
        product_d    = '0;
        sum_row      = pp[0];
        carry_row    = 1'b0;
        product_d[0] = pp[0][0];
        // Each stage shifts the running row right by one; its LSB is a final
        // product bit and the previous carry-out enters as the new MSB.
        for (int unsigned i = 1; i < 16; i++) begin
            {carry_row, sum_row} = cla16({carry_row, sum_row[15:1]}, pp[i]);
            product_d[i] = sum_row[0];
        end
        product_d[31:16] = {carry_row, sum_row[15:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            product_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                product_q <= product_d;
            end
        end
    end

    assign product   = product_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_array_cla_multiplier.sv
// Self-checking bench for array_cla_multiplier: vector table, directed
// corner sequences and a randomised run against a queue-based scoreboard.
module tb_array_cla_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic [31:0] product;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] sb[$];
    logic [31:0] hold_val = '0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    array_cla_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .product   (product)
    );

    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then check on the falling edge.
    task automatic step(input string name, input logic v, input logic r,
                        input logic [15:0] x, input logic [15:0] y, input logic [31:0] exp);
        logic [31:0] want;
        rst = r; in_valid = v; a = x; b = y;
        if (v && !r) sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        if (r) begin
            sb.delete();
            hold_val = '0;
        end
        check({name, ".valid"}, {31'b0, out_valid}, {31'b0, v && !r});
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s.queue: got output with empty scoreboard, required none", name);
            end else begin
                want = sb.pop_front();
                hold_val = want;
            end
        end
        check({name, ".product"}, product, hold_val);
    endtask

    initial begin
        vec_t vecs[11];
        vecs[0]  = '{16'd0,     16'd0,     32'd0};
        vecs[1]  = '{16'd1,     16'd1,     32'd1};
        vecs[2]  = '{16'hFFFF,  16'd1,     32'd65535};
        vecs[3]  = '{16'hFFFF,  16'hFFFF,  32'hFFFE0001};
        vecs[4]  = '{16'd32767, 16'd2,     32'd65534};
        vecs[5]  = '{16'd3,     16'd7,     32'd21};
        vecs[6]  = '{16'd255,   16'd255,   32'd65025};
        vecs[7]  = '{16'd999,   16'd111,   32'd110889};
        vecs[8]  = '{16'd1234,  16'd5678,  32'd7006652};
        vecs[9]  = '{16'd5555,  16'd3333,  32'd18514815};
        vecs[10] = '{16'd42,    16'd73,    32'd3066};

        rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;

        step("reset0", 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 32'd0);
        step("reset1", 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 32'd0);
        step("post_reset", 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'd0);

        for (int i = 0; i < 11; i++) begin
            step($sformatf("vec%0d", i), 1'b1, 1'b0, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        step("hold_load", 1'b1, 1'b0, 16'd100, 16'd200, 32'd20000);
        step("hold0",     1'b0, 1'b0, 16'd7,   16'd9,   32'd0);
        step("hold1",     1'b0, 1'b0, 16'd8,   16'd11,  32'd0);

        step("rst_mid",   1'b1, 1'b1, 16'd25,  16'd40,  32'd0);
        step("after_rst", 1'b1, 1'b0, 16'd10,  16'd20,  32'd200);

        for (int i = 0; i < 10000; i++) begin
            logic [15:0] ra, rb;
            logic        rv;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ((i % 97) == 0) ra = 16'hFFFF;
            if ((i % 89) == 0) rb = 16'hFFFF;
            rv = ($urandom_range(0, 3) != 0);
            step("random", rv, 1'b0, ra, rb, {16'b0, ra} * {16'b0, rb});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
